// File: rtl/gpu_isa_pkg.sv
// Shared ISA constants, fetch state encoding and opcode field helper for the shader core
// front end (fetch and decode).
package gpu_isa_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LDI = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_ST  = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'b1111;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_e;

  // LSB position of the opcode field, which occupies the top OPC_W bits of an instruction.
  function automatic int unsigned opc_lsb(input int unsigned instr_w);
    return instr_w - OPC_W;
  endfunction

endpackage

// File: rtl/gpu_pc_next.sv
// Combinational next-PC select (jump target vs pc+1) and the self-jump halt qualifier.
module gpu_pc_next
  import gpu_isa_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter bit          HALT_EN = 1'b0
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [PC_W-1:0]  target,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  instr_pc,
  output logic [PC_W-1:0]  pc_next_c,
  output logic             halt_c
);

  logic is_jmp_c;

  assign is_jmp_c  = (opcode == OPC_JMP);
  // pc+1 wraps at 2^PC_W by construction.
  assign pc_next_c = is_jmp_c ? target : pc + 1'b1;
  assign halt_c    = HALT_EN && is_jmp_c && (target == instr_pc);

endmodule

// File: rtl/gpu_fetch_unit.sv
// Instruction fetch/issue sequencer: fetches from imem over req/valid, issues to decode over
// valid/ready, redirects on jump. Optional halt on self-jump: FETCH_HALT_ON_SELF_JUMP_EN.
module gpu_fetch_unit
  import gpu_isa_pkg::*;
#(
  parameter int unsigned     INSTR_W  = 16,
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

`ifdef FETCH_HALT_ON_SELF_JUMP_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam int unsigned OPC_LSB = opc_lsb(INSTR_W);

  fetch_state_e    state, state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next_c;
  logic            halt_c;
  logic            restart_c, capture_c, accept_c;

  gpu_pc_next #(
    .PC_W    (PC_W),
    .HALT_EN (HALT_EN)
  ) u_pc_next (
    .opcode    (instr[OPC_LSB +: OPC_W]),
    .target    (instr[PC_W-1:0]),
    .pc        (pc),
    .instr_pc  (instr_pc),
    .pc_next_c (pc_next_c),
    .halt_c    (halt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    restart_c  = 1'b0;
    capture_c  = 1'b0;
    accept_c   = 1'b0;
    unique case (state)
      FS_IDLE: begin
        if (start) begin
          state_next = FS_REQ;
          restart_c  = 1'b1;
        end
      end
      FS_REQ: begin
        if (imem_rvalid) begin
          state_next = FS_ISSUE;
          capture_c  = 1'b1;
        end
      end
      FS_ISSUE: begin
        if (instr_ready) begin
          accept_c   = 1'b1;
          state_next = halt_c ? FS_IDLE : FS_REQ;
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= START_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      retired     <= '0;
    end else begin
      imem_req    <= (state_next == FS_REQ);
      instr_valid <= (state_next == FS_ISSUE);
      busy        <= (state_next != FS_IDLE);
      if (restart_c) begin
        pc      <= START_PC;
        retired <= '0;
      end else if (accept_c) begin
        pc <= pc_next_c;
        if (retired != '1) retired <= retired + 1'b1;
      end
      if (capture_c) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Self-checking bench for gpu_fetch_unit: scenario tasks compared against a behavioural
// program-order model and an instruction memory responder with randomized latency.
module tb_gpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_req, imem_rvalid, instr_valid, instr_ready, busy;
  logic [7:0]  imem_addr, instr_pc;
  logic [15:0] imem_rdata, instr;
  logic [15:0] retired;

  logic [15:0] imem [0:255];
  bit          mem_en, force_rv;
  logic [15:0] force_data;
  int          mem_lat;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  m_pc;
  int          m_ret;

  gpu_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory responder: answers a held request after mem_lat cycles, or replays a forced response.
  initial begin : responder
    int  wait_cnt;
    bit  fire;
    wait_cnt = 0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      fire = 1'b0;
      if (mem_en && imem_req) begin
        if (wait_cnt >= mem_lat) begin fire = 1'b1; wait_cnt = 0; end
        else wait_cnt++;
      end else wait_cnt = 0;
      imem_rvalid = mem_en ? fire : force_rv;
      imem_rdata  = mem_en ? imem[imem_addr] : force_data;
    end
  end

  // Reference program order: jumps take the low byte, everything else steps by one mod 256.
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [15:0] w);
    int unsigned p, v;
    p = pc;
    v = w;
    if (v / 4096 == 15) return 8'(v % 256);
    return 8'((p + 1) % 256);
  endfunction

  task automatic do_reset();
    instr_ready = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  // Waits for an issued instruction, optionally stalls, then accepts it.
  task automatic fetch_one(input int stall, output bit ok, output logic [15:0] o_instr,
                           output logic [7:0] o_pc, output bit stable);
    logic [15:0] r0;
    ok = 1'b0;
    stable = 1'b1;
    o_instr = '0;
    o_pc = '0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    o_instr = instr;
    o_pc = instr_pc;
    r0 = retired;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (instr !== o_instr || instr_pc !== o_pc || retired !== r0 ||
          imem_req !== 1'b0 || instr_valid !== 1'b1) stable = 1'b0;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (instr !== 16'h0) $display("FAIL reset_instr got=%h exp=0", instr); else n_pass++;
    n_checks++; if (instr_pc !== 8'h0) $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); else n_pass++;
    n_checks++; if (retired !== 16'h0) $display("FAIL reset_retired got=%0d exp=0", retired); else n_pass++;
    n_checks++; if (imem_addr !== 8'h0) $display("FAIL reset_addr got=%h exp=0", imem_addr); else n_pass++;
  endtask

  task automatic test_linear();
    bit ok, st;
    logic [15:0] oi, ew;
    logic [7:0] op;
    do_reset();
    clear_mem();
    imem[0] = 16'h7001; imem[1] = 16'h7002; imem[2] = 16'h0000; imem[3] = 16'h9003;
    mem_lat = 1;
    do_start();
    m_pc = 8'h00; m_ret = 0;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, m_pc}) $display("FAIL lin_first_req got=%b/%h exp=1/%h", imem_req, imem_addr, m_pc);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      fetch_one(0, ok, oi, op, st);
      n_checks++; if (!ok) begin $display("FAIL lin_timeout k=%0d", k); return; end else n_pass++;
      ew = imem[m_pc];
      n_checks++; if (op !== m_pc) $display("FAIL lin_pc k=%0d got=%h exp=%h", k, op, m_pc); else n_pass++;
      n_checks++; if (oi !== ew) $display("FAIL lin_instr k=%0d got=%h exp=%h", k, oi, ew); else n_pass++;
      m_ret++; m_pc = model_next(m_pc, ew);
      n_checks++; if (retired !== 16'(m_ret)) $display("FAIL lin_retired k=%0d got=%0d exp=%0d", k, retired, m_ret); else n_pass++;
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, m_pc}) $display("FAIL lin_next_req k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, m_pc);
      else n_pass++;
    end
  endtask

  task automatic test_jump_wrap();
    bit ok, st;
    logic [15:0] oi, ew;
    logic [7:0] op;
    do_reset();
    clear_mem();
    imem[8'h00] = 16'hF005; imem[8'h05] = 16'hF020; imem[8'h20] = 16'hF0FF; imem[8'hFF] = 16'h7123;
    mem_lat = 2;
    do_start();
    m_pc = 8'h00; m_ret = 0;
    for (int k = 0; k < 4; k++) begin
      fetch_one(0, ok, oi, op, st);
      n_checks++; if (!ok) begin $display("FAIL jmp_timeout k=%0d", k); return; end else n_pass++;
      ew = imem[m_pc];
      n_checks++; if (op !== m_pc || oi !== ew) $display("FAIL jmp_issue k=%0d got=%h@%h exp=%h@%h", k, oi, op, ew, m_pc); else n_pass++;
      m_ret++; m_pc = model_next(m_pc, ew);
      n_checks++; if (imem_addr !== m_pc) $display("FAIL jmp_addr k=%0d got=%h exp=%h", k, imem_addr, m_pc); else n_pass++;
      if (k == 1) begin
        n_checks++; if (imem_addr !== 8'h20) $display("FAIL jmp_target got=%h exp=20", imem_addr); else n_pass++;
      end
      if (k == 3) begin
        n_checks++; if (imem_addr !== 8'h00) $display("FAIL pc_wrap got=%h exp=00", imem_addr); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, st;
    logic [15:0] oi;
    logic [7:0] op;
    do_reset();
    clear_mem();
    imem[0] = 16'h7001; imem[1] = 16'h7002;
    mem_lat = 1;
    do_start();
    fetch_one(5, ok, oi, op, st);
    n_checks++; if (!ok) begin $display("FAIL bp_timeout"); return; end else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL bp_stable got=%b exp=1", st); else n_pass++;
    n_checks++; if (oi !== 16'h7001 || op !== 8'h00) $display("FAIL bp_instr got=%h@%h exp=7001@00", oi, op); else n_pass++;
    n_checks++; if (retired !== 16'd1) $display("FAIL bp_retired got=%0d exp=1", retired); else n_pass++;
    n_checks++; if (imem_addr !== 8'h01) $display("FAIL bp_next_addr got=%h exp=01", imem_addr); else n_pass++;
  endtask

  task automatic test_random();
    bit ok, st;
    logic [15:0] oi, ew;
    logic [7:0] op;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'($urandom);
      if ($urandom_range(3, 0) == 0) imem[i] = {4'hF, 4'h0, 8'($urandom)};
      if (imem[i][15:12] == 4'hF && imem[i][7:0] == 8'(i)) imem[i][7:0] = 8'(i + 1);
    end
    mem_lat = $urandom_range(3, 1);
    do_start();
    m_pc = 8'h00; m_ret = 0;
    for (int k = 0; k < 20; k++) begin
      fetch_one($urandom_range(2, 0), ok, oi, op, st);
      n_checks++; if (!ok) begin $display("FAIL rnd_timeout k=%0d", k); return; end else n_pass++;
      ew = imem[m_pc];
      n_checks++;
      if (op !== m_pc || oi !== ew || st !== 1'b1) $display("FAIL rnd_issue k=%0d got=%h@%h st=%b exp=%h@%h", k, oi, op, st, ew, m_pc);
      else n_pass++;
      m_ret++; m_pc = model_next(m_pc, ew);
      n_checks++; if (retired !== 16'(m_ret)) $display("FAIL rnd_retired k=%0d got=%0d exp=%0d", k, retired, m_ret); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_en = 1'b0; force_rv = 1'b0; force_data = 16'h7055;
    @(negedge clk);
    do_start();
    n_checks++; if (imem_req !== 1'b1) $display("FAIL mid_req got=%b exp=1", imem_req); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL mid_async got=%b/%b exp=0/0", imem_req, busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    force_rv = 1'b1;
    repeat (2) @(negedge clk);
    force_rv = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL mid_late_rvalid got=%b/%b/%b exp=0/0/0", busy, instr_valid, imem_req);
    else n_pass++;
    n_checks++; if (instr !== 16'h0) $display("FAIL mid_instr got=%h exp=0", instr); else n_pass++;
    mem_en = 1'b1;
  endtask

  task automatic test_self_jump();
    bit ok, st;
    logic [15:0] oi, ew;
    logic [7:0] op;
    do_reset();
    clear_mem();
    imem[0] = 16'h7001; imem[1] = 16'h7002; imem[2] = 16'h0000; imem[3] = 16'h9003; imem[4] = 16'hF004;
    mem_lat = 1;
    do_start();
    m_pc = 8'h00; m_ret = 0;
    for (int k = 0; k < 5; k++) begin
      fetch_one(0, ok, oi, op, st);
      n_checks++; if (!ok) begin $display("FAIL sj_timeout k=%0d", k); return; end else n_pass++;
      ew = imem[m_pc];
      n_checks++; if (op !== m_pc || oi !== ew) $display("FAIL sj_issue k=%0d got=%h@%h exp=%h@%h", k, oi, op, ew, m_pc); else n_pass++;
      m_ret++; m_pc = model_next(m_pc, ew);
    end
`ifdef FETCH_HALT_ON_SELF_JUMP_EN
    n_checks++; if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL sj_halt got=%b/%b exp=0/0", busy, imem_req); else n_pass++;
    n_checks++; if (retired !== 16'd5) $display("FAIL sj_retired got=%0d exp=5", retired); else n_pass++;
`else
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h04}) $display("FAIL sj_refetch got=%b/%h exp=1/04", imem_req, imem_addr); else n_pass++;
    fetch_one(0, ok, oi, op, st);
    n_checks++; if (!ok || op !== 8'h04 || oi !== 16'hF004) $display("FAIL sj_loop got=%h@%h ok=%b exp=f004@04", oi, op, ok); else n_pass++;
    n_checks++; if (retired !== 16'd6 || imem_addr !== 8'h04) $display("FAIL sj_loop_cnt got=%0d/%h exp=6/04", retired, imem_addr); else n_pass++;
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    mem_en = 1'b1; force_rv = 1'b0; force_data = '0; mem_lat = 1;
    clear_mem();
    test_reset();
    test_linear();
    test_jump_wrap();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_self_jump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
